trace_monitor: RTL
==================

# trace_monitor

Synthesizable multi-channel commit-trace capture unit for the SoC. It timestamps retire-side events from the CPU (register writeback, CSR write, store, plus further channels), buffers them per channel, and drains them in round-robin order over a single valid/ready stream to a host-side sink. It also performs host-address completion detection and a cycle-budget timeout, replacing simulation-only monitors with logic usable on FPGA.

## Interface
- CHANNELS, 3, number of independent trace sources (1..8)
- DEPTH, 16, per-channel FIFO entries; power of two, >= 2
- CW, max(1,$clog2(CHANNELS)), channel-index width (derived, not overridden)
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low; state cleared on any rising edge where reset==0
- ch_valid  in  CHANNELS  per-channel event strobe, one-cycle qualifying
- ch_pc  in  CHANNELS*32  per-channel PC, channel i at [32*i +: 32]
- ch_addr  in  CHANNELS*32  register index / CSR address / store address
- ch_data  in  CHANNELS*32  write data
- ch_strb  in  CHANNELS*4  byte enables (0 for non-store channels)
- host_addr  in  32  completion word address; compared on bits [31:2]
- mem_valid, mem_wstrb(4), mem_addr(32), mem_wdata(32)  in  data-memory request
- stoptime  in  32  cycle budget; 0 disables timeout
- out_valid  out  1  trace record available
- out_ready  in  1  sink accepts record
- out_channel  out  CW  source channel
- out_time, out_pc, out_addr, out_data  out  32 each  record fields
- out_strb  out  4  record byte enables
- done  out  1  sticky completion
- timeout  out  1  sticky; completion caused by budget expiry
- done_code  out  32  mem_wdata latched at host write
- drop_count  out  16  saturating count of records lost to full FIFOs

## Operation
- cycle counter: 32-bit, 0 in reset, +1 every cycle, wraps; it is the timestamp.
- Capture: each cycle, for every i with ch_valid[i]==1 and done==0, push {cycle, pc, addr, data, strb} into FIFO i. Full FIFO: record dropped, drop_count += number of dropped records that cycle, saturating at 0xFFFF.
- Host detect: mem_valid && |mem_wstrb && mem_addr[31:2]==host_addr[31:2] -> done=1, done_code=mem_wdata, timeout stays 0.
- Timeout: stoptime!=0 && cycle==stoptime && done==0 -> done=1, timeout=1, done_code=0. Host detect in the same cycle wins (timeout=0).
- Capture in the cycle done rises is still accepted; from the next cycle none. FIFOs keep draining after done.
- Arbiter: rr pointer (reset 0). When output register is empty or handshaking, grant first non-empty FIFO at index >= pointer, wrapping; pop it, load output register, pointer = grant+1 mod CHANNELS.
- done, timeout, done_code, drop_count hold until reset.

## Timing
- Reset values: out_valid 0, all out_* fields 0, done 0, timeout 0, done_code 0, drop_count 0, pointer 0, FIFOs empty.
- Latency: event at edge N -> out_valid at edge N+2 when the path is idle (FIFO write N, output register load N+1).
- Handshake: transfer when out_valid && out_ready at a rising edge; out_* stable while out_valid && !out_ready; back-to-back records at one per cycle.
- FIFO push and pop the same cycle on a full FIFO: pop first, push accepted, no drop.
- done rises at edge following the detecting cycle; done_code valid same edge.
- Reset mid-operation discards all buffered records.

## Structure
- Shared package: trace_record_type struct {time, pc, addr, data, strb}, trace channel index constants (TRACE_REG=0, TRACE_CSR=1, TRACE_MEM=2).
- Sub-module trace_fifo: parametric DEPTH, synchronous FIFO of trace_record_type with full/empty flags; instantiated CHANNELS times via generate.
- Top holds counter, completion logic, arbiter, output register.

## Test plan
- Single event ch0 pc=0x80000000 addr=5 data=0x12345678 at cycle 20, out_ready=1 -> one record, channel 0, out_time=20, out_valid at cycle 22.
- All three channels valid at cycle 30 -> three records channel order 0,1,2, all out_time=30, consecutive cycles.
- out_ready=0, ch1 valid 20 consecutive cycles, DEPTH=16 -> 17 records reach buffer (16 FIFO + 1 output reg), drop_count=3; release ready -> 17 records in order.
- Store to host_addr with wdata=42 while ch0 streams -> done=1, done_code=42, timeout=0; no records with time after detect cycle; buffered ones drain.
- stoptime=100, no host write -> done=1, timeout=1 at edge 101; host write exactly at cycle 100 -> timeout=0.
- reset low for one cycle with 5 buffered records -> out_valid=0 next cycle, drop_count=0, counter restarts at 0.

Source files
------------

// File: rtl/trace_monitor_pkg.sv
// Shared types for the commit-trace capture unit: the buffered record layout
// and the fixed channel assignments used by the CPU retire side.
package trace_monitor_pkg;

    localparam int TRACE_REG = 0;
    localparam int TRACE_CSR = 1;
    localparam int TRACE_MEM = 2;

    // "time" is a reserved word, so the timestamp field is called stamp.
    typedef struct packed {
        logic [31:0] stamp;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } trace_record_type;

endpackage

// File: rtl/trace_monitor_fifo.sv
// Per-channel synchronous FIFO of trace records with full/empty flags.
// Read data is combinational so the top's output register is the only read stage.
module trace_fifo
    import trace_monitor_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  trace_record_type push_data,
    input  logic             pop,
    output trace_record_type pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    trace_record_type mem_reg [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    assign pop_data = mem_reg[rd_ptr_reg[AW-1:0]];
    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    // Extra pointer bit distinguishes a full ring from an empty one.
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/trace_monitor.sv
// Multi-channel commit-trace capture: timestamps retire events, buffers them per
// channel and drains round-robin over one valid/ready stream; detects completion.
module trace_monitor
    import trace_monitor_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int DEPTH    = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [CHANNELS-1:0]          ch_valid,
    input  logic [CHANNELS*32-1:0]       ch_pc,
    input  logic [CHANNELS*32-1:0]       ch_addr,
    input  logic [CHANNELS*32-1:0]       ch_data,
    input  logic [CHANNELS*4-1:0]        ch_strb,
    input  logic [31:0]                  host_addr,
    input  logic                         mem_valid,
    input  logic [3:0]                   mem_wstrb,
    input  logic [31:0]                  mem_addr,
    input  logic [31:0]                  mem_wdata,
    input  logic [31:0]                  stoptime,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] out_channel,
    output logic [31:0]                  out_time,
    output logic [31:0]                  out_pc,
    output logic [31:0]                  out_addr,
    output logic [31:0]                  out_data,
    output logic [3:0]                   out_strb,
    output logic                         done,
    output logic                         timeout,
    output logic [31:0]                  done_code,
    output logic [15:0]                  drop_count
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [31:0]      cycle_reg;
    logic             done_reg;
    logic             timeout_reg;
    logic [31:0]      done_code_reg;
    logic [15:0]      drop_count_reg;
    logic [CW-1:0]    ptr_reg;
    logic             out_valid_reg;
    logic [CW-1:0]    out_channel_reg;
    trace_record_type out_rec_reg;

    trace_record_type push_rec [CHANNELS];
    trace_record_type pop_rec  [CHANNELS];
    logic [CHANNELS-1:0] full_vec, empty_vec, push_vec, pop_vec, drop_vec;

    logic             capture_en;
    logic             host_hit;
    logic             timeout_hit;
    logic             load_en;
    logic             grant_valid;
    logic [CW-1:0]    grant_idx;
    logic [CW-1:0]    ptr_next;
    trace_record_type grant_rec;
    logic [3:0]       drop_total;
    logic [16:0]      drop_sum;

    assign capture_en  = !done_reg;
    // Word-address match: the low two address bits are masked out.
    assign host_hit    = mem_valid && (|mem_wstrb) &&
                         (((mem_addr ^ host_addr) & 32'hFFFF_FFFC) == 32'd0);
    assign timeout_hit = (stoptime != 32'd0) && (cycle_reg == stoptime);
    assign load_en     = !out_valid_reg || out_ready;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign push_rec[gi] = '{stamp: cycle_reg,
                                    pc:    ch_pc[32*gi +: 32],
                                    addr:  ch_addr[32*gi +: 32],
                                    data:  ch_data[32*gi +: 32],
                                    strb:  ch_strb[4*gi +: 4]};
            // A same-cycle pop frees a slot, so a full FIFO still accepts the push.
            assign push_vec[gi] = ch_valid[gi] && capture_en && (!full_vec[gi] || pop_vec[gi]);
            assign drop_vec[gi] = ch_valid[gi] && capture_en && full_vec[gi] && !pop_vec[gi];
            assign pop_vec[gi]  = load_en && grant_valid && (grant_idx == CW'(gi));

            trace_fifo #(.DEPTH(DEPTH)) u_fifo (
                .clock     (clock),
                .reset     (reset),
                .push      (push_vec[gi]),
                .push_data (push_rec[gi]),
                .pop       (pop_vec[gi]),
                .pop_data  (pop_rec[gi]),
                .full      (full_vec[gi]),
                .empty     (empty_vec[gi])
            );
        end
    endgenerate

    // Round-robin search starting at the pointer, wrapping past the last channel.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!grant_valid && !empty_vec[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = CW'(idx);
            end
        end
        grant_rec = pop_rec[grant_idx];
        ptr_next  = (int'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + 1'b1;
    end

    always_comb begin
        drop_total = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            drop_total = drop_total + 4'(drop_vec[k]);
        end
        drop_sum = {1'b0, drop_count_reg} + 17'(drop_total);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cycle_reg      <= '0;
            done_reg       <= 1'b0;
            timeout_reg    <= 1'b0;
            done_code_reg  <= '0;
            drop_count_reg <= '0;
        end else begin
            cycle_reg      <= cycle_reg + 32'd1;
            drop_count_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (!done_reg) begin
                if (host_hit) begin
                    done_reg      <= 1'b1;
                    done_code_reg <= mem_wdata;
                end else if (timeout_hit) begin
                    done_reg      <= 1'b1;
                    timeout_reg   <= 1'b1;
                    done_code_reg <= '0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            out_valid_reg   <= 1'b0;
            out_channel_reg <= '0;
            out_rec_reg     <= '0;
            ptr_reg         <= '0;
        end else if (load_en) begin
            out_valid_reg <= grant_valid;
            if (grant_valid) begin
                out_channel_reg <= grant_idx;
                out_rec_reg     <= grant_rec;
                ptr_reg         <= ptr_next;
            end
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_channel = out_channel_reg;
    assign out_time    = out_rec_reg.stamp;
    assign out_pc      = out_rec_reg.pc;
    assign out_addr    = out_rec_reg.addr;
    assign out_data    = out_rec_reg.data;
    assign out_strb    = out_rec_reg.strb;
    assign done        = done_reg;
    assign timeout     = timeout_reg;
    assign done_code   = done_code_reg;
    assign drop_count  = drop_count_reg;

endmodule
